seq_alu: RTL and testbench

Multi-cycle execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder, plus two 32-bit operands, and returns a registered result through a valid/ready handshake. Logic, add/sub and compare ops finish one cycle after acceptance. Shifts run iteratively, one bit per cycle, unless the fast-shift option is compiled in. It sits in the execute stage between operand select and writeback, and stalls the front end through `in_ready`.

---
 rtl/seq_alu_pkg.sv | 28 ++
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu_core.sv | 30 +++
 rtl/seq_alu.sv | 102 ++++++++++
 tb/tb_seq_alu.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared ALU definitions: control codes (common with the control decoder), FSM states and width.
// Optional build macro SEQ_ALU_FAST_SHIFT_EN is consumed by seq_alu and alu_core.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between operand select, seq_alu and writeback.
interface seq_alu_if;
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_ctrl, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_ctrl, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );

endinterface

// File: rtl/seq_alu_core.sv
// Combinational evaluation of logic/arith/compare codes; also shifts when SEQ_ALU_FAST_SHIFT_EN is defined.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]      ctrl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o
);

    always_comb begin
        res_o = a_i + b_i;
        case (ctrl_i)
            ALU_ADD:  res_o = a_i + b_i;
            ALU_SUB:  res_o = a_i - b_i;
            ALU_AND:  res_o = a_i & b_i;
            ALU_OR:   res_o = a_i | b_i;
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
`ifdef SEQ_ALU_FAST_SHIFT_EN
            ALU_SLL:  res_o = a_i << b_i[4:0];
            ALU_SRL:  res_o = a_i >> b_i[4:0];
            ALU_SRA:  res_o = $signed(a_i) >>> b_i[4:0];
`endif
            default:  res_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit with valid/ready handshake; shifts iterate one bit per cycle
// unless SEQ_ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module seq_alu
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    state_e          state_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [XLEN-1:0] core_res;

    alu_core u_core (
        .ctrl_i (bus.alu_ctrl),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .res_o  (core_res)
    );

`ifndef SEQ_ALU_FAST_SHIFT_EN
    logic [3:0]      op_q;
    logic [XLEN-1:0] sh_q;
    logic [XLEN-1:0] sh_d;
    logic [4:0]      cnt_q;

    // SRA keeps replicating bit 31, which still holds the original sign of a.
    always_comb begin
        sh_d = sh_q;
        case (op_q)
            ALU_SLL: sh_d = {sh_q[XLEN-2:0], 1'b0};
            ALU_SRL: sh_d = {1'b0, sh_q[XLEN-1:1]};
            default: sh_d = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifndef SEQ_ALU_FAST_SHIFT_EN
            op_q     <= ALU_ADD;
            sh_q     <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
`ifndef SEQ_ALU_FAST_SHIFT_EN
                        if (is_shift_op(bus.alu_ctrl) && (bus.b[4:0] != 5'd0)) begin
                            op_q    <= bus.alu_ctrl;
                            sh_q    <= bus.a;
                            cnt_q   <= bus.b[4:0];
                            state_q <= SHIFT;
                        end else if (is_shift_op(bus.alu_ctrl)) begin
                            result_q <= bus.a;
                            zero_q   <= (bus.a == '0);
                            state_q  <= DONE;
                        end else begin
                            result_q <= core_res;
                            zero_q   <= (core_res == '0);
                            state_q  <= DONE;
                        end
`else
                        result_q <= core_res;
                        zero_q   <= (core_res == '0);
                        state_q  <= DONE;
`endif
                    end
                end
`ifndef SEQ_ALU_FAST_SHIFT_EN
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_q <= sh_d;
                        zero_q   <= (sh_d == '0);
                        state_q  <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed literal cases plus randomized traffic checked every cycle
// against an op-level model (result + expected latency). Honors SEQ_ALU_FAST_SHIFT_EN.
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nFail = 0;
    bit   checking = 1'b0;

    seq_alu_if bus ();

    seq_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int sh;
        logic [31:0] r;
        sh = int'(y[4:0]);
        case (op)
            4'd1: r = x - y;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6: r = (x < y) ? 32'd1 : 32'd0;
            4'd7: r = x << sh;
            4'd8: r = x >> sh;
            4'd9: begin
                r = x >> sh;
                if (x[31] && sh > 0) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            default: r = x + y;
        endcase
        return r;
    endfunction

    // Extra cycles an accepted op spends before its result shows up.
    function automatic int extraWait(input logic [3:0] op, input logic [31:0] y);
`ifdef SEQ_ALU_FAST_SHIFT_EN
        return 0;
`else
        return (op >= 4'd7 && op <= 4'd9) ? int'(y[4:0]) : 0;
`endif
    endfunction

    function automatic int shLat(input int n);
`ifdef SEQ_ALU_FAST_SHIFT_EN
        return 1;
`else
        return (n == 0) ? 1 : n + 1;
`endif
    endfunction

    bit          mBusy = 1'b0;
    int          mWait = 0;
    logic [31:0] mRes = '0;
    logic [31:0] mShown = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mBusy  = 1'b0;
            mWait  = 0;
            mRes   = '0;
            mShown = '0;
        end else if (!mBusy) begin
            if (bus.in_valid) begin
                mBusy = 1'b1;
                mRes  = refAlu(bus.alu_ctrl, bus.a, bus.b);
                mWait = extraWait(bus.alu_ctrl, bus.b);
                if (mWait == 0) mShown = mRes;
            end
        end else if (mWait > 0) begin
            mWait--;
            if (mWait == 0) mShown = mRes;
        end else if (bus.out_ready) begin
            mBusy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cyc_in_ready", 32'(bus.in_ready), 32'(!mBusy));
            checkOutput("cyc_out_valid", 32'(bus.out_valid), 32'(mBusy && mWait == 0));
            checkOutput("cyc_result", bus.result, mShown);
            checkOutput("cyc_zero", 32'(bus.zero), 32'(mShown == '0));
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) checkOutput("issue_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = op;
        bus.a        = x;
        bus.b        = y;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] expRes, input int expLat);
        int lat;
        applyStimulus(op, x, y);
        waitValid(lat);
        checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_res"}, bus.result, expRes);
        checkOutput({name, "_zero"}, 32'(bus.zero), 32'(expRes == '0));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        @(posedge clk); #1;
        checking = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_result", bus.result, 32'h0);
        checkOutput("rst_zero", 32'(bus.zero), 32'd1);

        runOp("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
        runOp("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'h0, 1);
        runOp("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        runOp("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        runOp("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        runOp("xor", ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
        runOp("code12_add", 4'd12, 32'd3, 32'd4, 32'd7, 1);
        runOp("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, shLat(4));
        runOp("srl4", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, shLat(4));
        runOp("sll0", ALU_SLL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        runOp("sll32", ALU_SLL, 32'h1234_5678, 32'h20, 32'h1234_5678, 1);
        runOp("sll31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, shLat(31));

        // Backpressure: output stalls while requests keep arriving.
        applyStimulus(ALU_ADD, 32'd10, 32'd20);
        waitValid(lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2) == 0;
            bus.alu_ctrl = ALU_SUB;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk); #1;
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_result", bus.result, 32'd30);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("bp_single_output", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of an iterative shift.
        applyStimulus(ALU_SLL, 32'h0000_0F0F, 32'd20);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_result", bus.result, 32'h0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        runOp("post_rst_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1);

        // Randomized traffic; the per-cycle compare process does the checking.
        repeat (3000) begin
            @(posedge clk); #1;
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.alu_ctrl  = 4'($urandom_range(0, 15));
            bus.a         = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            bus.b         = ($urandom_range(0, 5) == 0) ? bus.a : $urandom;
            bus.out_ready = $urandom_range(0, 3) != 0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("drain_idle", 32'(bus.in_ready), 32'd1);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
